// File: rtl/sr_ff_pkg.sv
// Shared encodings for the SR flip-flop slice: {s,r} command codes, reset value
// and the per-bit next-state rule.
package sr_ff_pkg;

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_RST  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_ILL  = 2'b11;

   localparam logic Q_RST = 1'b0;

   // The illegal command resolves to hold so the cell never produces X.
   function automatic logic sr_next(input logic [1:0] cmd, input logic q_cur);
      logic nxt;
      nxt = q_cur;
      case (cmd)
         CMD_HOLD: nxt = q_cur;
         CMD_RST:  nxt = 1'b0;
         CMD_SET:  nxt = 1'b1;
         CMD_ILL:  nxt = q_cur;
         default:  nxt = q_cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_ff_async_bit.sv
// Single SR storage cell with asynchronous active-low clear (dominant) and preset.
// Optional registered illegal-command flag under SR_FF_ILLEGAL_FLAG_EN.
module sr_ff_async_bit
   import sr_ff_pkg::*;
(
   input  logic clk_i,
   input  logic clear_ni,
   input  logic preset_ni,
   input  logic s_i,
   input  logic r_i,
   output logic q_o,
   output logic qb_o
`ifdef SR_FF_ILLEGAL_FLAG_EN
   ,
   output logic ill_o
`endif
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = sr_next({s_i, r_i}, q_q);
   end

   always_ff @(posedge clk_i or negedge clear_ni or negedge preset_ni) begin
      if (!clear_ni) begin
         q_q <= Q_RST;
      end else if (!preset_ni) begin
         q_q <= ~Q_RST;
      end else begin
         q_q <= q_d;
      end
   end

   // Output override keeps the forced value visible while an async input is
   // held low, including when clear rises with preset still asserted.
   always_comb begin
      if (!clear_ni) begin
         q_o = Q_RST;
      end else if (!preset_ni) begin
         q_o = ~Q_RST;
      end else begin
         q_o = q_q;
      end
      qb_o = ~q_o;
   end

`ifdef SR_FF_ILLEGAL_FLAG_EN
   logic ill_q;

   always_ff @(posedge clk_i or negedge clear_ni or negedge preset_ni) begin
      if (!clear_ni || !preset_ni) begin
         ill_q <= 1'b0;
      end else begin
         ill_q <= ({s_i, r_i} == CMD_ILL);
      end
   end

   assign ill_o = ill_q & clear_ni & preset_ni;
`endif

endmodule

// File: rtl/sr_ff_async.sv
// WIDTH-wide bank of independent SR flip-flops with async active-low preset/clear.
// Define SR_FF_ILLEGAL_FLAG_EN to add the registered 'illegal' output.
module sr_ff_async
   import sr_ff_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clk,
   input  logic             preset,
   input  logic             clear,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
`ifdef SR_FF_ILLEGAL_FLAG_EN
   ,
   output logic             illegal
`endif
);

`ifdef SR_FF_ILLEGAL_FLAG_EN
   logic [WIDTH-1:0] ill_bits;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sr_ff_async_bit u_cell (
         .clk_i     (clk),
         .clear_ni  (clear),
         .preset_ni (preset),
         .s_i       (s[i]),
         .r_i       (r[i]),
         .q_o       (q[i]),
         .qb_o      (qb[i])
`ifdef SR_FF_ILLEGAL_FLAG_EN
         ,
         .ill_o     (ill_bits[i])
`endif
      );
   end

`ifdef SR_FF_ILLEGAL_FLAG_EN
   assign illegal = |ill_bits;
`endif

endmodule

// File: tb/tb_sr_ff_async.sv
// Directed bench for sr_ff_async (WIDTH=4): async priority, SR commands, illegal hold.
module tb_sr_ff_async;

   logic       clk;
   logic [3:0] s;
   logic [3:0] r;
   logic       preset;
   logic       clear;
   logic [3:0] q;
   logic [3:0] qb;
`ifdef SR_FF_ILLEGAL_FLAG_EN
   logic       illegal;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bit          done     = 1'b0;

   sr_ff_async #(.WIDTH(4)) dut (
      .s       (s),
      .r       (r),
      .clk     (clk),
      .preset  (preset),
      .clear   (clear),
      .q       (q),
      .qb      (qb)
`ifdef SR_FF_ILLEGAL_FLAG_EN
      ,
      .illegal (illegal)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic exp_q(input string tag, input logic [3:0] e);
      chk({tag, ".q"}, {28'b0, q}, {28'b0, e});
      chk({tag, ".qb"}, {28'b0, qb}, {28'b0, ~e});
   endtask

   task automatic exp_ill(input string tag, input logic e);
`ifdef SR_FF_ILLEGAL_FLAG_EN
      chk({tag, ".ill"}, {31'b0, illegal}, {31'b0, e});
`else
      if (e) begin
         $display("note: %s expects illegal=1 (flag not built)", tag);
      end
`endif
   endtask

   task automatic drive(input logic [3:0] s_v, input logic [3:0] r_v,
                        input logic pre_v, input logic clr_v);
      s      = s_v;
      r      = r_v;
      preset = pre_v;
      clear  = clr_v;
      #1;
   endtask

   task automatic pos_edge();
      @(posedge clk);
      #1;
   endtask

   // qb must be the exact complement of q at all times.
   always @(q or qb) begin
      #1;
      if (!done) chk("qb_inv", {28'b0, q ^ qb}, 32'h0000_000F);
   end

   initial begin
      // 1: both async low, clear dominates
      drive(4'h0, 4'h0, 1'b0, 1'b0);
      exp_q("t1_reset", 4'h0);
      exp_ill("t1_reset", 1'b0);

      // 2: preset only, reset command ignored
      @(negedge clk);
      drive(4'h0, 4'hF, 1'b0, 1'b1);
      exp_q("t2_now", 4'hF);
      pos_edge(); exp_q("t2_e1", 4'hF);
      pos_edge(); exp_q("t2_e2", 4'hF);

      // 3: clear only, set command ignored
      @(negedge clk);
      drive(4'hF, 4'h0, 1'b1, 1'b0);
      exp_q("t3_now", 4'h0);
      pos_edge(); exp_q("t3_e1", 4'h0);
      pos_edge(); exp_q("t3_e2", 4'h0);
      exp_ill("t3_e2", 1'b0);

      // 4: synchronous commands
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b1, 1'b1);
      exp_q("t4_rel", 4'h0);
      pos_edge(); exp_q("t4_hold0", 4'h0);
      @(negedge clk);
      drive(4'b1010, 4'h0, 1'b1, 1'b1);
      exp_q("t4_pre_edge", 4'h0);
      pos_edge(); exp_q("t4_set", 4'b1010);
      @(negedge clk);
      drive(4'h0, 4'b0010, 1'b1, 1'b1);
      pos_edge(); exp_q("t4_rst", 4'b1000);
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b1, 1'b1);
      pos_edge(); exp_q("t4_hold", 4'b1000);
      @(negedge clk);
      drive(4'b0111, 4'b1000, 1'b1, 1'b1);
      pos_edge(); exp_q("t4_mix", 4'b0111);

      // 5: illegal command holds; flag tracks it
      @(negedge clk);
      drive(4'b1110, 4'b0110, 1'b1, 1'b1);
      pos_edge(); exp_q("t5_e1", 4'hF); exp_ill("t5_e1", 1'b1);
      pos_edge(); exp_q("t5_e2", 4'hF); exp_ill("t5_e2", 1'b1);
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b1, 1'b1);
      exp_ill("t5_pre", 1'b1);
      pos_edge(); exp_q("t5_off", 4'hF); exp_ill("t5_off", 1'b0);
      @(negedge clk);
      drive(4'h0, 4'b0001, 1'b1, 1'b1);
      pos_edge(); exp_q("t5_r0", 4'b1110);
      @(negedge clk);
      drive(4'b0001, 4'b0001, 1'b1, 1'b1);
      pos_edge(); exp_q("t5_ill0", 4'b1110); exp_ill("t5_ill0", 1'b1);

      // 6: load 1010, then clear mid-cycle without a clock edge
      @(negedge clk);
      drive(4'b1010, 4'b0101, 1'b1, 1'b1);
      pos_edge(); exp_q("t6_load", 4'b1010); exp_ill("t6_load", 1'b0);
      @(negedge clk);
      drive(4'b0001, 4'b0001, 1'b1, 1'b1);
      pos_edge(); exp_q("t6_ill", 4'b1010); exp_ill("t6_ill", 1'b1);
      #5;
      drive(4'b0001, 4'b0001, 1'b1, 1'b0);
      exp_q("t6_clr", 4'h0); exp_ill("t6_clr", 1'b0);
      @(negedge clk);
      drive(4'hF, 4'h0, 1'b1, 1'b0);
      pos_edge(); exp_q("t6_clr_edge", 4'h0);
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b1, 1'b1);
      pos_edge(); exp_q("t6_rel_hold", 4'h0);

      // preset mid-cycle overrides a pending reset command
      @(negedge clk);
      drive(4'h0, 4'hF, 1'b1, 1'b1);
      #3;
      drive(4'h0, 4'hF, 1'b0, 1'b1);
      exp_q("t6_pre", 4'hF);
      pos_edge(); exp_q("t6_pre_edge", 4'hF);
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b1, 1'b1);
      pos_edge(); exp_q("t6_pre_hold", 4'hF);
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b0, 1'b0);
      exp_q("t6_both", 4'h0);

      #3;
      done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
